// File: rtl/vedic_pkg.sv
// Shared definitions for the iterative Vedic multiplier: controller states,
// nibble width and the nibble-counter width helper.
package vedic_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that indexes n nibbles; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul4x4.sv
// Vedic (Urdhva Tiryagbhyam) 4x4 unsigned multiplier built from four 2x2
// vertical-and-crosswise blocks combined with shifted additions.
module mul4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  function automatic logic [3:0] vedic2x2(input logic [1:0] x, input logic [1:0] y);
    logic       c1;
    logic [3:0] p;
    p[0] = x[0] & y[0];
    p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    c1   = x[1] & y[0] & x[0] & y[1];
    p[2] = (x[1] & y[1]) ^ c1;
    p[3] = x[1] & y[1] & c1;
    return p;
  endfunction

  logic [3:0] w_q0, w_q1, w_q2, w_q3;
  logic [4:0] w_mid;

  always_comb begin
    w_q0  = vedic2x2(i_a[1:0], i_b[1:0]);
    w_q1  = vedic2x2(i_a[3:2], i_b[1:0]);
    w_q2  = vedic2x2(i_a[1:0], i_b[3:2]);
    w_q3  = vedic2x2(i_a[3:2], i_b[3:2]);
    w_mid = {1'b0, w_q1} + {1'b0, w_q2};
    o_p   = {4'b0000, w_q0} + {1'b0, w_mid, 2'b00} + {w_q3, 4'b0000};
  end

endmodule

// File: rtl/vedic_seq_mul.sv
// WIDTH x WIDTH multiplier that time-shares one mul4x4 core over all nibble
// pairs. Define VEDIC_SEQ_SIGNED_EN for two's-complement operands.
module vedic_seq_mul
  import vedic_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int unsigned N  = WIDTH / NIBBLE_W;
  localparam int unsigned CW = cnt_w(N);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t                 r_state, w_next;
  logic [WIDTH-1:0]       r_op_a, r_op_b;
  logic [PW-1:0]          r_acc, r_result;
  logic [CW-1:0]          r_i, r_j;
  logic [NIBBLE_W-1:0]    w_nib_a, w_nib_b;
  logic [2*NIBBLE_W-1:0]  w_prod;
  logic [CW:0]            w_ij;
  logic [PW-1:0]          w_addend, w_sum, w_final;
  logic [WIDTH-1:0]       w_cap_a, w_cap_b;
  logic                   w_last;

  assign w_nib_a  = r_op_a[int'(r_i) * NIBBLE_W +: NIBBLE_W];
  assign w_nib_b  = r_op_b[int'(r_j) * NIBBLE_W +: NIBBLE_W];
  assign w_ij     = {1'b0, r_i} + {1'b0, r_j};
  assign w_addend = PW'(w_prod) << (int'(w_ij) * NIBBLE_W);
  assign w_sum    = r_acc + w_addend;
  assign w_last   = (r_i == LAST) && (r_j == LAST);

  mul4x4 u_core (
    .i_a (w_nib_a),
    .i_b (w_nib_b),
    .o_p (w_prod)
  );

`ifdef VEDIC_SEQ_SIGNED_EN
  // Magnitudes are multiplied unsigned; the sign is applied once at the end.
  logic r_neg;
  assign w_cap_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
  assign w_cap_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  assign w_final = r_neg ? (~w_sum + PW'(1)) : w_sum;

  always_ff @(posedge clk) begin
    if (rst)
      r_neg <= 1'b0;
    else if (r_state == ST_IDLE && in_valid)
      r_neg <= a[WIDTH-1] ^ b[WIDTH-1];
  end
`else
  assign w_cap_a = a;
  assign w_cap_b = b;
  assign w_final = w_sum;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default:                w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_i      <= '0;
      r_j      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_op_a   <= w_cap_a;
          r_op_b   <= w_cap_b;
          r_acc    <= '0;
          r_result <= '0;
          r_i      <= '0;
          r_j      <= '0;
        end
        ST_RUN: begin
          r_acc <= w_sum;
          if (r_j == LAST) begin
            r_j <= '0;
            r_i <= r_i + CW'(1);
          end else begin
            r_j <= r_j + CW'(1);
          end
          // Result register only moves at the final step, including the last addend.
          if (w_last)
            r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign result    = r_result;

endmodule

// File: tb/tb_vedic_seq_mul.sv
// Self-checking bench for vedic_seq_mul (WIDTH=16): directed latency,
// backpressure and reset cases, then random traffic against a scoreboard.
module tb_vedic_seq_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned pushes = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  vedic_seq_mul #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
`ifdef VEDIC_SEQ_SIGNED_EN
    int sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 32'(sx * sy);
`else
    logic [31:0] ux, uy;
    ux = {16'h0000, x};
    uy = {16'h0000, y};
    return ux * uy;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, log handshakes into the scoreboard, advance one edge.
  task automatic step(input logic v, input logic [15:0] ia, input logic [15:0] ib,
                      input logic ordy, input logic [31:0] e);
    logic [31:0] exp_r;
    in_valid  = v;
    a         = ia;
    b         = ib;
    out_ready = ordy;
    if (v && in_ready === 1'b1) begin
      sb.push_back(e);
      pushes++;
    end
    if (out_valid === 1'b1 && ordy) begin
      chk("pop_nonempty", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_r = sb.pop_front();
        chk("result", result, exp_r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Accept one operation and wait (bounded) for DONE, checking latency.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic [31:0] e);
    int c;
    chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
    step(1'b1, ia, ib, 1'b0, e);
    c = 1;
    while (out_valid !== 1'b1 && c < 40) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      step(1'b0, 16'h0, 16'h0, 1'b0, 32'h0);
      c++;
    end
    chk("latency", 32'(c), 32'd17);
  endtask

  task automatic drain_op();
    step(1'b0, 16'h0, 16'h0, 1'b1, 32'h0);
    chk("idle_after_done", {30'b0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    int unsigned start, cyc;
    logic        v, r;
    logic [15:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", result, 32'h0);

    run_op(16'h1234, 16'h5678, 32'h06260060);
    drain_op();
`ifdef VEDIC_SEQ_SIGNED_EN
    run_op(16'h8000, 16'h8000, 32'h40000000);
    drain_op();
    run_op(16'hFFFF, 16'h0003, 32'hFFFFFFFD);
    drain_op();
    run_op(16'h8000, 16'h7FFF, 32'hC0008000);
    drain_op();
    run_op(16'hFFFF, 16'hFFFF, 32'h00000001);
    drain_op();
`else
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    drain_op();
`endif
    run_op(16'h0000, 16'hBEEF, 32'h00000000);
    drain_op();

    // Backpressure: DONE held for 10 cycles with a competing in_valid.
    run_op(16'h00FF, 16'h0101, 32'h0000FFFF);
    held = result;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, ref_mul(16'hDEAD, 16'hBEEF));
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_result_stable", result, held);
    end
    chk("bp_no_capture", 32'(sb.size()), 32'd1);
    step(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, ref_mul(16'hDEAD, 16'hBEEF));
    chk("bp_release_idle", {30'b0, out_valid, in_ready}, 32'd1);
    chk("bp_release_sb", 32'(sb.size()), 32'd0);
    run_op(16'hDEAD, 16'hBEEF, ref_mul(16'hDEAD, 16'hBEEF));
    drain_op();

    // Reset during RUN cycle 8 aborts the operation.
    step(1'b1, 16'hAAAA, 16'h5555, 1'b0, ref_mul(16'hAAAA, 16'h5555));
    for (int i = 1; i < 8; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 32'h0);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b1, 32'h0);
    rst = 1'b0;
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    if (sb.size() != 0) void'(sb.pop_back());
    run_op(16'h0003, 16'h0005, 32'h0000000F);
    drain_op();

    // Random traffic with random in_valid / out_ready.
    start = pushes;
    cyc   = 0;
    while (((pushes - start) < 1000 || sb.size() != 0) && cyc < 60000) begin
      v  = ((pushes - start) < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      r  = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = 16'($urandom);
      step(v, ra, rb, r, ref_mul(ra, rb));
      cyc++;
    end
    chk("rand_accepted", 32'(pushes - start), 32'd1000);
    chk("rand_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
